// File: rtl/fp32_pkg.sv
// Shared types and constants for the FP32 operation dispatcher and its arithmetic units.
package fp32_pkg;

    localparam int FP32_W = 32;
    localparam logic [FP32_W-1:0] FP32_QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        RESP
    } disp_state_t;

endpackage

// File: rtl/fp32_op_dispatcher.sv
// Issues one operand pair to the FP32 adder and multiplier, pulses their reset as a start,
// collects both results (or QNAN on timeout) and returns them over a valid/ready port.
//   state | meaning
//   IDLE  | ready for a request, operands latched on accept
//   START | one-cycle start pulse on the units' reset input, done ignored
//   WAIT  | capture first done of each unit, count towards timeout
//   RESP  | response held until rsp_ready
module fp32_op_dispatcher
    import fp32_pkg::*;
#(
    parameter int                TIMEOUT_CYCLES = 64,
    parameter logic [FP32_W-1:0] QNAN           = FP32_QNAN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [FP32_W-1:0] req_x,
    input  logic [FP32_W-1:0] req_y,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [FP32_W-1:0] rsp_sum,
    output logic [FP32_W-1:0] rsp_prod,
    output logic              rsp_timeout,
    output logic [FP32_W-1:0] unit_x,
    output logic [FP32_W-1:0] unit_y,
    output logic              unit_start,
    input  logic [FP32_W-1:0] add_z,
    input  logic              add_done,
    input  logic [FP32_W-1:0] mul_z,
    input  logic              mul_done
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

    disp_state_t      state;
    disp_state_t      state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             add_got;
    logic             mul_got;
    logic             add_hit;
    logic             mul_hit;
    logic             add_got_nxt;
    logic             mul_got_nxt;
    logic             tmo_hit;
    logic             accept;

    assign req_ready  = (state == IDLE);
    assign rsp_valid  = (state == RESP);
    assign unit_start = (state == START);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        add_hit     = 1'b0;
        mul_hit     = 1'b0;
        tmo_hit     = 1'b0;
        add_got_nxt = add_got;
        mul_got_nxt = mul_got;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = START;
                end
            end
            START: state_nxt = WAIT;
            WAIT: begin
                add_hit     = !add_got && add_done;
                mul_hit     = !mul_got && mul_done;
                add_got_nxt = add_got || add_hit;
                mul_got_nxt = mul_got || mul_hit;
                // a done landing on the last cycle counts before the timeout decision
                tmo_hit     = !(add_got_nxt && mul_got_nxt) && (cnt == CNT_LAST);
                if ((add_got_nxt && mul_got_nxt) || tmo_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            unit_x      <= '0;
            unit_y      <= '0;
            rsp_sum     <= '0;
            rsp_prod    <= '0;
            rsp_timeout <= 1'b0;
            cnt         <= '0;
            add_got     <= 1'b0;
            mul_got     <= 1'b0;
        end else if (accept) begin
            unit_x      <= req_x;
            unit_y      <= req_y;
            rsp_timeout <= 1'b0;
            cnt         <= '0;
            add_got     <= 1'b0;
            mul_got     <= 1'b0;
        end else if (state == WAIT) begin
            add_got <= add_got_nxt;
            mul_got <= mul_got_nxt;
            if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
            if (add_hit) begin
                rsp_sum <= add_z;
            end else if (tmo_hit && !add_got) begin
                rsp_sum <= QNAN;
            end
            if (mul_hit) begin
                rsp_prod <= mul_z;
            end else if (tmo_hit && !mul_got) begin
                rsp_prod <= QNAN;
            end
            if (tmo_hit) begin
                rsp_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fp32_op_dispatcher.sv
// Bench for fp32_op_dispatcher: two instances (default timeout and TIMEOUT_CYCLES=8) driven
// against latency-programmable unit models, table-driven vectors plus hand-written sequences.
module tb_fp32_op_dispatcher;
    import fp32_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid [2];
    logic        req_ready [2];
    logic [31:0] req_x [2];
    logic [31:0] req_y [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_sum [2];
    logic [31:0] rsp_prod [2];
    logic        rsp_timeout [2];
    logic [31:0] unit_x [2];
    logic [31:0] unit_y [2];
    logic        unit_start [2];
    logic [31:0] add_z [2];
    logic        add_done [2];
    logic [31:0] mul_z [2];
    logic        mul_done [2];

    // unit model configuration: latency 0 means the unit never finishes
    int          add_lat [2];
    int          mul_lat [2];
    logic [31:0] add_val [2];
    logic [31:0] mul_val [2];
    bit          glitch [2];
    int          acnt [2];
    int          mcnt [2];
    bit          a_fired [2];

    int n_pass = 0;
    int n_tot  = 0;

    fp32_op_dispatcher dut_0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_x(req_x[0]), .req_y(req_y[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_sum(rsp_sum[0]), .rsp_prod(rsp_prod[0]),
        .rsp_timeout(rsp_timeout[0]), .unit_x(unit_x[0]), .unit_y(unit_y[0]), .unit_start(unit_start[0]),
        .add_z(add_z[0]), .add_done(add_done[0]), .mul_z(mul_z[0]), .mul_done(mul_done[0])
    );

    fp32_op_dispatcher #(.TIMEOUT_CYCLES(8)) dut_1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_x(req_x[1]), .req_y(req_y[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_sum(rsp_sum[1]), .rsp_prod(rsp_prod[1]),
        .rsp_timeout(rsp_timeout[1]), .unit_x(unit_x[1]), .unit_y(unit_y[1]), .unit_start(unit_start[1]),
        .add_z(add_z[1]), .add_done(add_done[1]), .mul_z(mul_z[1]), .mul_done(mul_done[1])
    );

    // Unit models: start-by-reset, done rises in WAIT cycle <lat> and then stays high.
    // With glitch set, the adder toggles done and inverts z every cycle after finishing.
    always @(posedge clk or posedge reset) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                add_done[d] <= 1'b0;
                mul_done[d] <= 1'b0;
                add_z[d]    <= '0;
                mul_z[d]    <= '0;
                acnt[d]     <= 0;
                mcnt[d]     <= 0;
                a_fired[d]  <= 1'b0;
            end else if (unit_start[d]) begin
                add_done[d] <= (add_lat[d] == 1);
                mul_done[d] <= (mul_lat[d] == 1);
                if (add_lat[d] == 1) add_z[d] <= add_val[d];
                if (mul_lat[d] == 1) mul_z[d] <= mul_val[d];
                a_fired[d]  <= (add_lat[d] == 1);
                acnt[d]     <= (add_lat[d] > 1) ? add_lat[d] - 1 : 0;
                mcnt[d]     <= (mul_lat[d] > 1) ? mul_lat[d] - 1 : 0;
            end else begin
                if (acnt[d] > 0) begin
                    acnt[d] <= acnt[d] - 1;
                    if (acnt[d] == 1) begin
                        add_done[d] <= 1'b1;
                        add_z[d]    <= add_val[d];
                        a_fired[d]  <= 1'b1;
                    end
                end else if (glitch[d] && a_fired[d]) begin
                    add_done[d] <= ~add_done[d];
                    add_z[d]    <= ~add_z[d];
                end
                if (mcnt[d] > 0) begin
                    mcnt[d] <= mcnt[d] - 1;
                    if (mcnt[d] == 1) begin
                        mul_done[d] <= 1'b1;
                        mul_z[d]    <= mul_val[d];
                    end
                end
            end
        end
    end

    typedef struct {
        int          d;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] aval;
        logic [31:0] mval;
        int          alat;
        int          mlat;
        bit          glitch;
        logic [31:0] exp_sum;
        logic [31:0] exp_prod;
        bit          exp_tmo;
        int          exp_lat;
    } vec_t;

    vec_t vecs [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %b expected %b", name, act, exp);
        else n_pass++;
    endtask

    // Latency is counted in cycles from the accept cycle: START=1, first WAIT=2, ...
    task automatic run_op(input vec_t v);
        int d = v.d;
        int lat = 0;
        int starts = 0;
        add_lat[d]   = v.alat;
        mul_lat[d]   = v.mlat;
        add_val[d]   = v.aval;
        mul_val[d]   = v.mval;
        glitch[d]    = v.glitch;
        req_x[d]     = v.x;
        req_y[d]     = v.y;
        req_valid[d] = 1'b1;
        chk_b("req_ready_idle", req_ready[d], 1'b1);
        tick();
        req_valid[d] = 1'b0;
        lat = 1;
        chk_b("tmo_clear_start", rsp_timeout[d], 1'b0);
        chk("unit_x", unit_x[d], v.x);
        chk("unit_y", unit_y[d], v.y);
        while (!rsp_valid[d] && lat < 40) begin
            if (unit_start[d]) starts++;
            tick();
            lat++;
        end
        chk_b("rsp_valid", rsp_valid[d], 1'b1);
        chk("latency", lat, v.exp_lat);
        chk("rsp_sum", rsp_sum[d], v.exp_sum);
        chk("rsp_prod", rsp_prod[d], v.exp_prod);
        chk_b("rsp_timeout", rsp_timeout[d], v.exp_tmo);
        chk("start_width", starts, 1);
    endtask

    task automatic finish_rsp(input int d);
        rsp_ready[d] = 1'b1;
        tick();
        rsp_ready[d] = 1'b0;
        chk_b("rsp_valid_drop", rsp_valid[d], 1'b0);
        chk_b("req_ready_back", req_ready[d], 1'b1);
    endtask

    initial begin
        vec_t bp1;
        vec_t bp2;
        vec_t post;
        bit   quiet;

        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            rsp_ready[d] = 1'b0;
            req_x[d]     = '0;
            req_y[d]     = '0;
            add_lat[d]   = 0;
            mul_lat[d]   = 0;
            add_val[d]   = '0;
            mul_val[d]   = '0;
            glitch[d]    = 1'b0;
        end

        //             d  x             y             add result    mul result    al  ml  gl sum           prod          tmo lat
        vecs[0] = '{0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4000_0000, 1,  1, 0, 32'h4040_0000, 32'h4000_0000, 0, 3};
        vecs[1] = '{0, 32'hBF80_0000, 32'h3F80_0000, 32'h0000_0000, 32'hBF80_0000, 4,  2, 0, 32'h0000_0000, 32'hBF80_0000, 0, 6};
        vecs[2] = '{0, 32'h4040_0000, 32'h4080_0000, 32'h40E0_0000, 32'h4140_0000, 3, 17, 1, 32'h40E0_0000, 32'h4140_0000, 0, 19};
        vecs[3] = '{0, 32'h7FA0_0001, 32'h0000_0001, 32'h7FE0_0001, 32'h7FE0_0001, 5,  5, 0, 32'h7FE0_0001, 32'h7FE0_0001, 0, 7};
        vecs[4] = '{1, 32'h4120_0000, 32'h40A0_0000, 32'h4170_0000, 32'h4248_0000, 2,  0, 0, 32'h4170_0000, 32'h7FC0_0000, 1, 10};
        vecs[5] = '{1, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 32'h3F80_0000, 1,  1, 0, 32'h4000_0000, 32'h3F80_0000, 0, 3};
        vecs[6] = '{1, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 32'h4080_0000, 8,  8, 0, 32'h4080_0000, 32'h4080_0000, 0, 10};
        vecs[7] = '{1, 32'h4040_0000, 32'h3F80_0000, 32'h4080_0000, 32'h4040_0000, 0,  0, 0, 32'h7FC0_0000, 32'h7FC0_0000, 1, 10};
        vecs[8] = '{1, 32'h3F00_0000, 32'h4000_0000, 32'h4020_0000, 32'h3F80_0000, 1,  9, 0, 32'h4020_0000, 32'h7FC0_0000, 1, 10};
        vecs[9] = '{1, 32'h40A0_0000, 32'h40A0_0000, 32'h4120_0000, 32'h41C8_0000, 0,  8, 0, 32'h7FC0_0000, 32'h41C8_0000, 1, 10};

        tick();
        tick();
        chk_b("rst_req_ready", req_ready[0], 1'b1);
        chk_b("rst_rsp_valid", rsp_valid[0], 1'b0);
        chk_b("rst_unit_start", unit_start[0], 1'b0);
        chk_b("rst_rsp_timeout", rsp_timeout[0], 1'b0);
        chk("rst_rsp_sum", rsp_sum[0], 32'h0);
        chk("rst_unit_x", unit_x[0], 32'h0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i]);
            finish_rsp(vecs[i].d);
        end
        chk_b("tmo_hold_idle", rsp_timeout[1], 1'b1);

        // backpressure with a second request waiting, then back-to-back accept
        bp1 = '{0, 32'h40A0_0000, 32'h4000_0000, 32'h40E0_0000, 32'h4120_0000, 1, 1, 0, 32'h40E0_0000, 32'h4120_0000, 0, 3};
        bp2 = '{0, 32'h3F00_0000, 32'h3F00_0000, 32'h3F80_0000, 32'h3E80_0000, 2, 1, 0, 32'h3F80_0000, 32'h3E80_0000, 0, 4};
        run_op(bp1);
        for (int i = 0; i < 5; i++) begin
            req_x[0]     = bp2.x;
            req_y[0]     = bp2.y;
            req_valid[0] = 1'b1;
            tick();
            chk_b("bp_rsp_valid", rsp_valid[0], 1'b1);
            chk_b("bp_req_ready", req_ready[0], 1'b0);
            chk("bp_sum", rsp_sum[0], bp1.exp_sum);
            chk("bp_prod", rsp_prod[0], bp1.exp_prod);
            chk("bp_unit_x", unit_x[0], bp1.x);
        end
        finish_rsp(0);
        run_op(bp2);
        finish_rsp(0);

        // reset pulsed in the middle of WAIT
        add_lat[0]   = 10;
        mul_lat[0]   = 10;
        add_val[0]   = 32'h4198_0000;
        mul_val[0]   = 32'h42B4_0000;
        req_x[0]     = 32'h4110_0000;
        req_y[0]     = 32'h4120_0000;
        req_valid[0] = 1'b1;
        tick();
        req_valid[0] = 1'b0;
        chk_b("mid_start", unit_start[0], 1'b1);
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk_b("mid_req_ready", req_ready[0], 1'b1);
        chk_b("mid_rsp_valid", rsp_valid[0], 1'b0);
        chk_b("mid_unit_start", unit_start[0], 1'b0);
        chk("mid_unit_x", unit_x[0], 32'h0);
        chk("mid_unit_y", unit_y[0], 32'h0);
        chk("mid_rsp_sum", rsp_sum[0], 32'h0);
        chk("mid_rsp_prod", rsp_prod[0], 32'h0);
        chk_b("mid_tmo_other", rsp_timeout[1], 1'b0);
        tick();
        reset = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (rsp_valid[0]) quiet = 1'b0;
            tick();
        end
        chk_b("mid_no_rsp", quiet, 1'b1);
        post = '{0, 32'h4040_0000, 32'h4040_0000, 32'h40C0_0000, 32'h4110_0000, 2, 3, 0, 32'h40C0_0000, 32'h4110_0000, 0, 5};
        run_op(post);
        finish_rsp(0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
